matmul_result_reader: RTL

Readout engine for the 3x3 MAC array. On a done strobe it captures all nine accumulator outputs in one cycle, then streams them out one element per handshake in row-major order (o11, o12, o13, o21, …, o33) with row/column tags and a last flag. One cycle after capture it pulses a clear to the array, so the next accumulation can start while the previous result is still draining.

---
 rtl/matmul_result_reader.sv | 99 +++++++++
 1 files changed

// File: rtl/matmul_result_reader.sv
// Readout engine for the 3x3 MAC array: snapshots nine accumulators
// and streams them row-major over a valid/ready handshake.
module matmul_result_reader #(
  parameter int DW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            acc_done,
  input  logic [9*DW-1:0] acc_flat,
  output logic            clear_out,
  output logic [DW-1:0]   dout,
  output logic [1:0]      dout_row,
  output logic [1:0]      dout_col,
  output logic            dout_last,
  output logic            dout_valid,
  input  logic            dout_ready,
  output logic            busy,
  output logic            overrun
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t          state_q;
  logic [9*DW-1:0] cap_q;
  logic [3:0]      idx_q;
  logic [3:0]      idx_d;
  logic [DW-1:0]   dout_q;
  logic [DW-1:0]   dout_d;
  logic [1:0]      row_q;
  logic [1:0]      col_q;
  logic            last_q;
  logic            valid_q;
  logic            clr_q;
  logic            ovr_q;
  logic            xfer;
  logic            fin;
  logic            take;

  assign xfer = (state_q == SEND) && dout_ready;
  assign fin  = xfer && (idx_q == 4'd8);
  // A strobe is accepted when idle or exactly on the final transfer.
  assign take = acc_done && ((state_q == IDLE) || fin);

  assign idx_d  = (idx_q == 4'd8) ? 4'd0 : idx_q + 4'd1;
  assign dout_d = cap_q[idx_d*DW +: DW];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cap_q   <= '0;
      idx_q   <= '0;
      dout_q  <= '0;
      row_q   <= '0;
      col_q   <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      clr_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      clr_q <= take;
      if (acc_done && !take) ovr_q <= 1'b1;
      if (take) begin
        state_q <= SEND;
        cap_q   <= acc_flat;
        idx_q   <= '0;
        dout_q  <= acc_flat[DW-1:0];
        row_q   <= '0;
        col_q   <= '0;
        last_q  <= 1'b0;
        valid_q <= 1'b1;
      end else if (fin) begin
        state_q <= IDLE;
        idx_q   <= '0;
        last_q  <= 1'b0;
        valid_q <= 1'b0;
      end else if (xfer) begin
        idx_q  <= idx_d;
        dout_q <= dout_d;
        last_q <= (idx_d == 4'd8);
        if (col_q == 2'd2) begin
          col_q <= '0;
          row_q <= row_q + 2'd1;
        end else begin
          col_q <= col_q + 2'd1;
        end
      end
    end
  end

  assign clear_out  = clr_q;
  assign dout       = dout_q;
  assign dout_row   = row_q;
  assign dout_col   = col_q;
  assign dout_last  = last_q;
  assign dout_valid = valid_q;
  assign busy       = (state_q == SEND);
  assign overrun    = ovr_q;

endmodule
